// File: rtl/seq_pattern_gen.sv
// ============================================================================
// Module   : seq_pattern_gen
// Brief    : Serial MSB-first pattern transmitter with repeat count, stall,
//            abort and optional inter-pass zero gaps (macro SEQ_GEN_GAP_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_pattern_gen #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [PAT_W-1:0] i_pat_in,
  input  logic [LEN_W-1:0] i_len_in,
  input  logic [CNT_W-1:0] i_rep_in,
  input  logic             i_stall,
  input  logic             i_abort,
`ifdef SEQ_GEN_GAP_EN
  input  logic [CNT_W-1:0] i_gap_in,
`endif
  output logic             o_x,
  output logic             o_x_valid,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [LEN_W-1:0] c_len_max = LEN_W'(PAT_W);
  localparam logic [PAT_W-1:0] c_one     = PAT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
`ifdef SEQ_GEN_GAP_EN
    , S_GAP = 2'd3
`endif
  } state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic [CNT_W-1:0] r_passes;
  logic             r_x;
  logic             r_xv;
  logic             r_done;
`ifdef SEQ_GEN_GAP_EN
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_gap_cnt;
`endif

  logic [LEN_W-1:0] w_len;
  logic [CNT_W-1:0] w_rep;
  logic             w_load_bit;
  logic             w_first_bit;
  logic             w_next_bit;

  // Out-of-range lengths and a zero repeat count fall back to full width / one pass.
  assign w_len       = (i_len_in == '0 || i_len_in > c_len_max) ? c_len_max : i_len_in;
  assign w_rep       = (i_rep_in == '0) ? CNT_W'(1) : i_rep_in;
  assign w_load_bit  = |(i_pat_in & (c_one << (w_len - 1'b1)));
  assign w_first_bit = |(r_pat & (c_one << (r_len - 1'b1)));
  assign w_next_bit  = |(r_pat & (c_one << (r_idx - 1'b1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pat     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_passes  <= '0;
      r_x       <= 1'b0;
      r_xv      <= 1'b0;
      r_done    <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      r_gap     <= '0;
      r_gap_cnt <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_pat    <= i_pat_in;
            r_len    <= w_len;
            r_idx    <= w_len - 1'b1;
            r_passes <= w_rep;
`ifdef SEQ_GEN_GAP_EN
            r_gap    <= i_gap_in;
`endif
            r_x      <= w_load_bit;
            r_xv     <= 1'b1;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (i_abort) begin
            r_x     <= 1'b0;
            r_xv    <= 1'b0;
            r_state <= S_IDLE;
          end else if (!i_stall) begin
            if (r_idx != '0) begin
              r_idx <= r_idx - 1'b1;
              r_x   <= w_next_bit;
            end else if (r_passes > CNT_W'(1)) begin
              r_passes <= r_passes - 1'b1;
`ifdef SEQ_GEN_GAP_EN
              if (r_gap != '0) begin
                r_gap_cnt <= r_gap;
                r_x       <= 1'b0;
                r_xv      <= 1'b0;
                r_state   <= S_GAP;
              end else
`endif
              begin
                r_idx <= r_len - 1'b1;
                r_x   <= w_first_bit;
              end
            end else begin
              r_x     <= 1'b0;
              r_xv    <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
`ifdef SEQ_GEN_GAP_EN
        S_GAP: begin
          if (i_abort) begin
            r_state <= S_IDLE;
          end else if (!i_stall) begin
            // The exiting edge already presents the first bit of the next pass.
            if (r_gap_cnt == CNT_W'(1)) begin
              r_idx   <= r_len - 1'b1;
              r_x     <= w_first_bit;
              r_xv    <= 1'b1;
              r_state <= S_SHIFT;
            end else begin
              r_gap_cnt <= r_gap_cnt - 1'b1;
            end
          end
        end
`endif
        S_DONE: r_state <= S_IDLE;
        default: begin
          r_x     <= 1'b0;
          r_xv    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_x       = r_x;
  assign o_x_valid = r_xv;
  assign o_done    = r_done;
  assign o_ready   = (r_state == S_IDLE);
`ifdef SEQ_GEN_GAP_EN
  assign o_busy    = (r_state == S_SHIFT) || (r_state == S_GAP);
`else
  assign o_busy    = (r_state == S_SHIFT);
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
// ============================================================================
// Module   : tb_seq_pattern_gen
// Brief    : Self-checking bench for seq_pattern_gen: output-stream model plus
//            directed vectors with literal expectations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_pattern_gen;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [PAT_W-1:0] pat = '0;
  logic [LEN_W-1:0] len = '0;
  logic [CNT_W-1:0] rep = '0;
  logic [CNT_W-1:0] gap = '0;
  logic             stall = 1'b0;
  logic             abort = 1'b0;
  logic             o_x, o_x_valid, o_ready, o_busy, o_done;

  int vec = 0;
  int err = 0;
  logic chk_en = 1'b0;

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_load    (load),
    .i_pat_in  (pat),
    .i_len_in  (len),
    .i_rep_in  (rep),
    .i_stall   (stall),
    .i_abort   (abort),
`ifdef SEQ_GEN_GAP_EN
    .i_gap_in  (gap),
`endif
    .o_x       (o_x),
    .o_x_valid (o_x_valid),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  initial forever #5 clk = ~clk;

  // Model: a transfer is a queue of (bit, valid) items; each unstalled edge pops one.
  typedef struct packed { logic x; logic v; } item_t;
  item_t m_q[$];
  item_t m_cur = '0;
  int    m_ph  = 0;  // 0 idle, 1 busy, 2 done

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_cur = '0; m_ph = 0;
    end else begin
      case (m_ph)
        0: if (load) begin
          int el, er, eg;
          el = (len == 0 || len > PAT_W) ? PAT_W : int'(len);
          er = (rep == 0) ? 1 : int'(rep);
`ifdef SEQ_GEN_GAP_EN
          eg = int'(gap);
`else
          eg = 0;
`endif
          for (int p = 0; p < er; p++) begin
            if (p > 0) for (int g = 0; g < eg; g++) m_q.push_back('{x: 1'b0, v: 1'b0});
            for (int b = el - 1; b >= 0; b--) m_q.push_back('{x: pat[b], v: 1'b1});
          end
          m_cur = m_q.pop_front();
          m_ph  = 1;
        end
        1: if (abort) begin
          m_q.delete(); m_cur = '0; m_ph = 0;
        end else if (!stall) begin
          if (m_q.size() == 0) begin m_cur = '0; m_ph = 2; end
          else m_cur = m_q.pop_front();
        end
        default: m_ph = 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic [4:0] act, exp;
      act = {o_x, o_x_valid, o_busy, o_ready, o_done};
      exp = {m_cur.x, m_cur.v, m_ph == 1, m_ph == 0, m_ph == 2};
      vec++;
      if (act !== exp) begin
        err++;
        $display("FAIL model t=%0t {x,xv,busy,ready,done} got %b expected %b", $time, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [63:0] cap;
  logic [63:0] xvh;
  int          cap_n;

  // Called on a negedge; returns on the negedge of cycle 1 after the accepting edge.
  task automatic do_load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                         input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] g);
    pat = p; len = l; rep = r; gap = g; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Collects the stream until done; ncyc is the cycle number (1-based) of done.
  task automatic run(input int budget, input int stall_at, input int stall_n, output int ncyc);
    cap = '0; xvh = '0; cap_n = 0; ncyc = 0;
    forever begin
      ncyc++;
      xvh = {xvh[62:0], o_x_valid};
      if (o_x_valid) begin cap = {cap[62:0], o_x}; cap_n++; end
      if (ncyc == stall_at) stall = 1'b1;
      if (ncyc == stall_at + stall_n) stall = 1'b0;
      if (o_done) break;
      if (ncyc >= budget) begin
        vec++; err++;
        $display("FAIL run_timeout got %0d cycles expected done", ncyc);
        break;
      end
      @(negedge clk);
    end
    stall = 1'b0;
  endtask

  initial begin
    int n;
    @(negedge clk); @(negedge clk);
    chk("reset_outs", {o_x, o_x_valid, o_busy, o_ready, o_done}, 5'b00010);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Single pass 1101
    do_load(8'h0D, 4'd4, 8'd1, 8'd0);
    run(40, 0, 0, n);
    chk("p1_bits", cap, 64'hD);
    chk("p1_count", cap_n, 4);
    chk("p1_done_cyc", n, 5);
    @(negedge clk);
    chk("p1_ready", o_ready, 1'b1);

    // Three passes, no gap
    do_load(8'h0D, 4'd4, 8'd3, 8'd0);
    run(60, 0, 0, n);
    chk("p3_bits", cap, 64'hDDD);
    chk("p3_done_cyc", n, 13);
    chk("p3_xv_contig", xvh, 64'h1FFE);
    @(negedge clk);

    // Stall 3 cycles on the second bit
    do_load(8'h0D, 4'd4, 8'd1, 8'd0);
    run(40, 2, 3, n);
    chk("stall_bits", cap, 64'h7D);
    chk("stall_done_cyc", n, 8);
    @(negedge clk);

    // Abort at bit 2, with an ignored load pulse while busy
    do_load(8'h0D, 4'd4, 8'd3, 8'd0);
    pat = 8'h00; len = 4'd4; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("busy_load_ignored", o_x, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_outs", {o_x, o_x_valid, o_busy, o_ready, o_done}, 5'b00010);
    @(negedge clk);
    chk("abort_no_done", o_done, 1'b0);

    // Reset at bit 2
    do_load(8'h0D, 4'd4, 8'd1, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outs", {o_x, o_x_valid, o_busy, o_ready, o_done}, 5'b00010);
    @(negedge clk);

    // len 0 and rep 0 fall back to 8 bits, one pass
    do_load(8'hA5, 4'd0, 8'd0, 8'd0);
    run(40, 0, 0, n);
    chk("len0_bits", cap, 64'hA5);
    chk("len0_done_cyc", n, 9);
    @(negedge clk);

    // len beyond PAT_W clamps to 8
    do_load(8'h3C, 4'd9, 8'd1, 8'd0);
    run(40, 0, 0, n);
    chk("len9_bits", cap, 64'h3C);
    chk("len9_count", cap_n, 8);
    @(negedge clk);

`ifdef SEQ_GEN_GAP_EN
    // 101 twice with a 2-cycle gap
    do_load(8'h05, 4'd3, 8'd2, 8'd2);
    run(40, 0, 0, n);
    chk("gap_bits", cap, 64'h2D);
    chk("gap_xv", xvh, 64'h1CE);
    chk("gap_done_cyc", n, 9);
    @(negedge clk);

    // Same, with the gap frozen for two cycles
    do_load(8'h05, 4'd3, 8'd2, 8'd2);
    run(40, 4, 2, n);
    chk("gapstall_xv", xvh, 64'h70E);
    chk("gapstall_done_cyc", n, 11);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern transmitter that drives the single-bit `x` input of the sequence detector used in the power-estimation flow. It accepts a pattern word, a length and a repeat count through a one-cycle load handshake, then shifts the pattern out MSB-first, one bit per clock. Optional zero-gaps are inserted between repetitions. It generates repeatable, programmable switching activity on the detector input, so that the gate-level VCD runs of the detector are reproducible.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits.
- `CNT_W`, default 8: width of the repeat counter and the gap counter.
- `LEN_W`, default `$clog2(PAT_W+1)`: width of the length field.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: load request, accepted only when `ready`=1.
- `pat_in` in `PAT_W`: pattern; bits `[len-1:0]` are used.
- `len_in` in `LEN_W`: pattern length; values 0 and values greater than `PAT_W` are treated as `PAT_W`.
- `rep_in` in `CNT_W`: number of passes; 0 is treated as 1.
- `stall` in 1: freezes the shifter while high.
- `abort` in 1: terminates the transfer immediately.
- `gap_in` in `CNT_W`: idle zero-bits between passes. Present only with `SEQ_GEN_GAP_EN`.
- `x` out 1: serial bit to the detector; registered.
- `x_valid` out 1: `x` carries a pattern bit this cycle; registered.
- `ready` out 1: high in IDLE only.
- `busy` out 1: high in SHIFT or GAP.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, SHIFT, GAP, DONE. Reset state is IDLE.
- Reset values: `x`=0, `x_valid`=0, `ready`=1, `busy`=0, `done`=0. All internal registers are cleared.
- IDLE:
  - On `load`&&`ready`, capture `pat`, `len`, `rep` and `gap`.
  - Set bit index to `len-1` and passes-left to `rep`.
  - Go to SHIFT, and in the same edge drive `x`=`pat[len-1]`, `x_valid`=1.
  - `load` is ignored in any state other than IDLE.
- SHIFT: each non-stalled edge advances the index by −1 and drives the next bit. After the bit at index 0 has been presented:
  - If passes-left > 1: decrement passes-left. Go to GAP if `gap`>0, otherwise reload index `len-1` and stay in SHIFT. In both cases there are no dead cycles.
  - If passes-left = 1: go to DONE, with `x`=0 and `x_valid`=0.
- GAP: drives `x`=0, `x_valid`=0 for exactly `gap` cycles (stall-frozen). It then returns to SHIFT with index `len-1`, presenting the first bit on the exiting edge.
- DONE: `done`=1 for one cycle, then IDLE.
- `stall`: while high in SHIFT or GAP, hold `x`, `x_valid`, the index and both counters. Has no effect in IDLE or DONE.
- `abort`: in SHIFT or GAP, go to IDLE on the next edge, with `x`=0, `x_valid`=0 and no `done` pulse. `abort` has priority over `stall`. If `abort` and `load` are both high in IDLE, the load is accepted.
- Whenever `x_valid`=0, `x` is 0.

## Timing
- Load accepted at edge N: first bit is visible in the cycle after edge N.
- Total transfer: `len*rep + gap*(rep-1)` cycles with `busy`=1, plus stall cycles.
- `done` is high in the cycle immediately after the last bit cycle. `ready` returns in the following cycle.
- Throughput is one bit per clock. There is no bubble between passes when the gap is 0.
- `rst` mid-transfer: all outputs take their reset values at that edge.

## Configuration
- `SEQ_GEN_GAP_EN` defined: the `gap_in` port and the GAP state exist, with behaviour as above.
- `SEQ_GEN_GAP_EN` undefined: there is no `gap_in` port and no GAP state. The gap is effectively 0, so passes are always back-to-back.

## Test plan
- `pat_in`=8'b0000_1101, `len_in`=4, `rep_in`=1 → `x`=1,1,0,1 on four consecutive `x_valid` cycles, `done` in the 5th cycle, `ready` in the 6th.
- Same pattern with `rep_in`=3 and gap 0 → 12 contiguous valid bits, 1101 1101 1101, then a single `done`.
- `SEQ_GEN_GAP_EN` with `gap_in`=2, `rep_in`=2, `len_in`=3, `pat`=3'b101 → `x`/`x_valid` sequence 1/1, 0/1, 1/1, 0/0, 0/0, 1/1, 0/1, 1/1, then `done`.
- `stall` held high for 3 cycles during the 2nd bit of pattern 1101 → bit 1 is held for 4 cycles total, the remaining bits are unchanged, and `done` is delayed by 3 cycles.
- `abort` asserted at bit 2, and separately `rst` asserted at bit 2 → next cycle `x`=0, `x_valid`=0, `busy`=0, `ready`=1, with no `done`. Any `load` pulse while `busy` is ignored.
- `len_in`=0, `rep_in`=0, `pat`=8'hA5 → a single pass of 8 bits, 1,0,1,0,0,1,0,1, then `done`.
